// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO_DEPTH-entry write buffer.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              send,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              parity_odd,
  output logic              Data_out,
  output logic              busy,
  output logic              sent,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               data_out_q, data_out_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  head;
  logic               push, pop, fifo_empty, bit_end;
  logic [IDX_W-1:0]   idx_inc;

`ifdef UART_TX_PARITY_EN
  logic par_odd_q, par_odd_d;
  logic parity_bit;
  assign parity_bit = (^word_q) ^ par_odd_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Full/empty come from the occupancy count so wrapped pointers never alias.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign push       = send && !fifo_full;
  assign overflow_d = send && fifo_full;
  assign head       = mem[rd_ptr_q];
  assign bit_end    = (cyc_q == CYC_LAST);
  assign idx_inc    = idx_q + 1'b1;

  assign Data_out = data_out_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign sent     = (state_q == STOP) && (idx_q == STOP_LAST) && bit_end;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    word_d     = word_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_odd_d  = par_odd_q;
`endif
    if (state_q != IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        data_out_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          word_d     = head;
          state_d    = START;
          cyc_d      = '0;
          data_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_odd_d  = parity_odd;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          idx_d      = '0;
          data_out_d = word_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
            data_out_d = parity_bit;
`else
            state_d    = STOP;
            idx_d      = '0;
            data_out_d = 1'b1;
`endif
          end else begin
            idx_d      = idx_inc;
            data_out_d = word_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          idx_d      = '0;
          data_out_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q != STOP_LAST) begin
            idx_d = idx_inc;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame without an idle bit.
            pop        = 1'b1;
            word_d     = head;
            state_d    = START;
            data_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_odd_d  = parity_odd;
`endif
          end else begin
            state_d    = IDLE;
            data_out_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        data_out_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= Data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      data_out_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      data_out_q <= data_out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      par_odd_q  <= par_odd_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4); frame length follows UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       send, send2;
  logic [7:0] data_in, data_in2;
  logic       parity_odd;
  logic       line1, busy1, sent1, full1, ovf1;
  logic       line2, busy2, sent2, full2, ovf2;
  logic       sel;
  logic       line_obs, busy_obs, sent_obs;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign line_obs = sel ? line2 : line1;
  assign busy_obs = sel ? busy2 : busy1;
  assign sent_obs = sel ? sent2 : sent1;

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clock(clk), .reset_n(reset_n), .send(send), .Data_in(data_in), .parity_odd(parity_odd),
    .Data_out(line1), .busy(busy1), .sent(sent1), .fifo_full(full1), .overflow(ovf1)
  );

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clock(clk), .reset_n(reset_n), .send(send2), .Data_in(data_in2), .parity_odd(parity_odd),
    .Data_out(line2), .busy(busy2), .sent(sent2), .fifo_full(full2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts sampling at the first negedge after the call; skip drops leading frame cycles.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic par,
                              input int nstop, input int skip);
    logic [11:0] bits;
    int          ncyc;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (PEN == 1) bits[9] = par;
    ncyc = (1 + 8 + PEN + nstop) * CPB;
    for (int k = skip; k < ncyc; k++) begin
      @(negedge clk);
      chk({tag, "_line"}, line_obs, bits[k/CPB]);
      chk({tag, "_sent"}, sent_obs, (k == ncyc - 1));
      chk({tag, "_busy"}, busy_obs, 1);
    end
    $display("frame %s data=%02h cycles=%0d", tag, d, ncyc);
  endtask

  // Returns right at the edge that moves the FSM into START.
  task automatic send_word(input logic [7:0] d, input logic odd);
    @(posedge clk); #1;
    send = 1'b1; data_in = d; parity_odd = odd;
    @(posedge clk); #1;
    send = 1'b0;
    chk("queued_busy", busy1, 1);
    chk("queued_line", line1, 1);
    @(posedge clk);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_line"}, line_obs, 1);
    chk({tag, "_busy"}, busy_obs, 0);
    chk({tag, "_sent"}, sent_obs, 0);
  endtask

  initial begin
    reset_n = 1'b0; send = 1'b0; send2 = 1'b0; data_in = '0; data_in2 = '0;
    parity_odd = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", line1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_sent", sent1, 0);
    chk("rst_full", full1, 0);
    chk("rst_ovf", ovf1, 0);
    reset_n = 1'b1;

    // 0xA5 even parity -> parity bit 0
    send_word(8'hA5, 1'b0);
    expect_frame("a5_even", 8'hA5, 1'b0, 1, 0);
    check_idle("a5_after");

    // 0x01 odd -> parity 0
    send_word(8'h01, 1'b1);
    expect_frame("01_odd", 8'h01, 1'b0, 1, 0);
    check_idle("01_after");

    // 0x00 odd -> parity 1; parity_odd flips after frame start and must be ignored
    send_word(8'h00, 1'b1);
    #1 parity_odd = 1'b0;
    expect_frame("00_odd", 8'h00, 1'b1, 1, 0);
    check_idle("00_after");

    // six consecutive writes from idle: 0x15 dropped, frames back to back
    @(posedge clk); #1;
    send = 1'b1; data_in = 8'h10; parity_odd = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      data_in = 8'h10 + 8'(i);
      chk("burst_full", full1, (i >= 5));
      chk("burst_ovf", ovf1, (i == 6));
      if (i == 6) send = 1'b0;
    end
    @(posedge clk); #1;
    chk("burst_ovf_end", ovf1, 0);
    chk("burst_full_hold", full1, 1);
    expect_frame("burst10", 8'h10, 1'b1, 1, 5);
    expect_frame("burst11", 8'h11, 1'b0, 1, 0);
    expect_frame("burst12", 8'h12, 1'b0, 1, 0);
    expect_frame("burst13", 8'h13, 1'b1, 1, 0);
    expect_frame("burst14", 8'h14, 1'b0, 1, 0);
    check_idle("burst_after");
    chk("burst_full_end", full1, 0);

    // asynchronous reset during data bit 3 with a second word still queued
    send_word(8'h00, 1'b0);
    #1 send = 1'b1; data_in = 8'h3C;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("mid_line", line1, 0);
    chk("mid_busy", busy1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_line", line1, 1);
    chk("arst_busy", busy1, 0);
    chk("arst_sent", sent1, 0);
    chk("arst_full", full1, 0);
    chk("arst_ovf", ovf1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 50; k++) check_idle("post_rst");
    $display("reset mid-frame: line idle, no frame resumed");

    // two stop bits on dut2
    sel = 1'b1;
    @(posedge clk); #1;
    send2 = 1'b1; data_in2 = 8'hFF;
    @(posedge clk); #1;
    send2 = 1'b0;
    @(posedge clk);
    expect_frame("ff_stop2", 8'hFF, 1'b0, 2, 0);
    check_idle("ff_after");
    chk("dut2_full", full2, 0);
    chk("dut2_ovf", ovf2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
